onehot_scan8: RTL

- Inverse companion to the 8-way OR reduction: the OR reports *whether* any lane is set; this block reports *which* lanes are set.
- Accepts an 8-bit vector via valid/ready, then emits the index of each set bit, one per beat, lowest index first, on a valid/ready output stream.
- Sits between flag-collection logic and a serial consumer, such as an interrupt or event dispatcher.

---
 rtl/onehot_scan8_pkg.sv | 9 +
 rtl/onehot_scan8_if.sv | 34 +++
 rtl/onehot_scan8_pri_enc8.sv | 18 +
 rtl/onehot_scan8.sv | 57 +++++
 4 files changed

// File: rtl/onehot_scan8_pkg.sv
// onehot_scan8_pkg: shared state encoding, default width and index-width helper
package onehot_scan8_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;
  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction
  localparam int DEF_IDX_W = idx_w(DEF_WIDTH);
endpackage

// File: rtl/onehot_scan8_if.sv
// onehot_scan8_if: vector-in / index-out streams (in_valid/in_ready/in_vec, out_valid/out_ready/out_idx/out_none/out_last, busy, out_count when ONEHOT_SCAN_POPCNT_EN)
interface onehot_scan8_if
  import onehot_scan8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDX_W = idx_w(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_none;
  logic             out_last;
  logic             busy;
`ifdef ONEHOT_SCAN_POPCNT_EN
  logic [IDX_W:0]   out_count;
`endif
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_last, busy
`ifdef ONEHOT_SCAN_POPCNT_EN
    , input out_count
`endif
  );
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_last, busy
`ifdef ONEHOT_SCAN_POPCNT_EN
    , output out_count
`endif
  );
endinterface

// File: rtl/onehot_scan8_pri_enc8.sv
// pri_enc8: combinational lowest-set-bit encoder; vec in, idx = lowest set position (0 if none), none = vec is all zero
module pri_enc8
  import onehot_scan8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]        vec,
  output logic [idx_w(WIDTH)-1:0] idx,
  output logic                    none
);
  localparam int IDX_W = idx_w(WIDTH);
  // scanning downward lets the lowest set bit win
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (vec[i]) idx = IDX_W'(i);
  end
  assign none = ~|vec;
endmodule

// File: rtl/onehot_scan8.sv
// onehot_scan8: emits the index of each set bit of a captured vector, lowest first; ports clk, rst_n (async active-low), bus (onehot_scan8_if.slave); ONEHOT_SCAN_POPCNT_EN adds out_count
module onehot_scan8
  import onehot_scan8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  onehot_scan8_if.slave  bus
);
  localparam int IDX_W = idx_w(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH-1:0] pending, pending_nx, rest;
  logic [IDX_W-1:0] idx;
  logic             none, emit, last, cap;
  pri_enc8 #(.WIDTH(WIDTH)) u_enc (.vec(pending), .idx(idx), .none(none));
  // rest drops the lowest set bit; it is zero exactly when at most one bit remains
  assign rest = pending & (pending - WIDTH'(1));
  assign last = rest == '0;
  assign emit = state == ST_EMIT;
  assign cap  = !emit && bus.in_valid;
  assign bus.in_ready  = !emit;
  assign bus.out_valid = emit;
  assign bus.out_idx   = idx;
  assign bus.out_none  = emit && none;
  assign bus.out_last  = emit && last;
  assign bus.busy      = emit;
  // on the last beat rest is already zero, so pending clears for free
  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    if (cap) begin
      state_nx   = ST_EMIT;
      pending_nx = bus.in_vec;
    end else if (emit && bus.out_ready) begin
      state_nx   = last ? ST_IDLE : ST_EMIT;
      pending_nx = rest;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
    end
  end
`ifdef ONEHOT_SCAN_POPCNT_EN
  logic [IDX_W:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (cap) count <= (IDX_W + 1)'($countones(bus.in_vec));
  end
  assign bus.out_count = count;
`endif
endmodule
